// File: rtl/lcd_write_engine.sv
// HD44780 bus-timing engine: one byte per valid/ready handshake, driven with setup/pulse/hold timing
// followed by the controller execution wait. Optional macro LCD_BUSY_POLL_EN swaps the fixed wait for busy-flag polling.
module lcd_write_engine #(
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 12,
  parameter int HOLD_CYC       = 2,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int POLL_LIMIT     = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_err,
  inout  wire  [7:0] io_LCD_DATA,
  output logic       o_LCD_EN,
  output logic       o_LCD_RS,
  output logic       o_LCD_RW,
  output logic       o_LCD_ON,
  output logic       o_LCD_BLON
);

  localparam int CNT_MAX = (LONG_WAIT_CYC > POLL_LIMIT) ? LONG_WAIT_CYC : POLL_LIMIT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  // Handshake: a request is taken on any rising edge where i_valid & o_ready; inputs are ignored afterwards.
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_PSETUP, S_PPULSE, S_PHOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;

`ifdef LCD_BUSY_POLL_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_q, poll_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          polling;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef LCD_BUSY_POLL_EN
      poll_q  <= poll_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    poll_d  = poll_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          rs_d    = i_rs;
          data_d  = i_data;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = EN_LD;
          state_d = S_PULSE;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
`ifdef LCD_BUSY_POLL_EN
          poll_d  = '0;
          cnt_d   = SETUP_LD;
          state_d = S_PSETUP;
`else
          // Clear and return-home instructions need the long execution time.
          if (!rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03))
            cnt_d = CW'(LONG_WAIT_CYC - 1);
          else
            cnt_d = CW'(SHORT_WAIT_CYC - 1);
          state_d = S_WAIT;
`endif
        end else cnt_d = cnt_q - 1'b1;
      end
`ifdef LCD_BUSY_POLL_EN
      S_PSETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = EN_LD;
          state_d = S_PPULSE;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_PPULSE: begin
        if (cnt_q == '0) begin
          busy_d  = io_LCD_DATA[7];
          poll_d  = poll_q + 1'b1;
          cnt_d   = HOLD_LD;
          state_d = S_PHOLD;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_PHOLD: begin
        if (cnt_q == '0) begin
          if (!busy_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (poll_q == PW'(POLL_LIMIT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = SETUP_LD;
            state_d = S_PSETUP;
          end
        end else cnt_d = cnt_q - 1'b1;
      end
`else
      S_WAIT: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q - 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ready    = (state_q == S_IDLE) & ~i_rst;
  assign o_done     = done_q;
  assign o_LCD_EN   = (state_q == S_PULSE) || (state_q == S_PPULSE);
  assign o_LCD_ON   = ~i_rst;
  assign o_LCD_BLON = ~i_rst;

`ifdef LCD_BUSY_POLL_EN
  assign polling     = (state_q == S_PSETUP) || (state_q == S_PPULSE) || (state_q == S_PHOLD);
  assign o_err       = err_q;
  assign o_LCD_RS    = polling ? 1'b0 : rs_q;
  assign o_LCD_RW    = polling;
  assign io_LCD_DATA = polling ? 8'hzz : data_q;
`else
  assign o_err       = 1'b0;
  assign o_LCD_RS    = rs_q;
  assign o_LCD_RW    = 1'b0;
  assign io_LCD_DATA = data_q;
`endif

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine: done-cycle scoreboard plus pin-level timing checks.
`timescale 1ns/1ps
module tb_lcd_write_engine;

  localparam int SETUP_CYC      = 2;
  localparam int EN_HIGH_CYC    = 12;
  localparam int HOLD_CYC       = 2;
  localparam int SHORT_WAIT_CYC = 2000;
  localparam int LONG_WAIT_CYC  = 82000;
`ifdef LCD_BUSY_POLL_EN
  localparam int POLL_LIMIT     = 4;
`else
  localparam int POLL_LIMIT     = 4096;
`endif
  localparam int PHASE = SETUP_CYC + EN_HIGH_CYC + HOLD_CYC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_rs = 1'b0;
  logic [7:0] i_data = 8'h00;
  wire        ready, done, err, en, rs, rw, lcd_on, lcd_blon;
  wire  [7:0] lcd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  int   en_pulses = 0;
  int   rd_pulses = 0;
  int   rd_rs_hi = 0;
  logic en_prev = 1'b0;

`ifdef LCD_BUSY_POLL_EN
  int busy_reads = 0;
  int reads = 0;
  // LCD model: answers reads with DB7 busy for the first busy_reads reads.
  assign lcd_data = (rw && en) ? {(reads < busy_reads), 7'b0} : 8'hzz;
`endif

  lcd_write_engine #(
    .SETUP_CYC(SETUP_CYC), .EN_HIGH_CYC(EN_HIGH_CYC), .HOLD_CYC(HOLD_CYC),
    .SHORT_WAIT_CYC(SHORT_WAIT_CYC), .LONG_WAIT_CYC(LONG_WAIT_CYC), .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_rs(i_rs), .i_data(i_data),
    .o_ready(ready), .o_done(done), .o_err(err), .io_LCD_DATA(lcd_data),
    .o_LCD_EN(en), .o_LCD_RS(rs), .o_LCD_RW(rw), .o_LCD_ON(lcd_on), .o_LCD_BLON(lcd_blon)
  );

  // clock / cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic r, input logic [7:0] d);
    if (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return PHASE + LONG_WAIT_CYC + 1;
    return PHASE + SHORT_WAIT_CYC + 1;
  endfunction

  // pin monitor and done scoreboard
  always @(negedge clk) begin
    if (en && !en_prev) begin
      en_pulses++;
      if (rw) rd_pulses++;
    end
`ifdef LCD_BUSY_POLL_EN
    if (!en && en_prev && rw) reads++;
`endif
    if (en && rw && rs) rd_rs_hi++;
    en_prev = en;
    if (!rst && done) begin
      chk("done_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("done_cycle", cyc, exp_q.pop_front());
    end
  end

  // driver: present one request at a negedge in idle; accepted at the next edge
  task automatic send(input logic r, input logic [7:0] d, input int l, input bit push);
    chk("ready_before_send", ready, 1);
    i_valid = 1'b1;
    i_rs    = r;
    i_data  = d;
    if (push) exp_q.push_back(cyc + l);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_flag(input string tag, input int limit, input bit want_err);
    int n = 0;
    while (!(want_err ? err : done) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, want_err ? err : done, 1);
  endtask

  initial begin
    int c0;
    int en_hi;
    int first_en;
    int last_en;
    int rdy_hi;

    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_on", lcd_on, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", ready, 1);
    chk("rel_en", en, 0);
    chk("rel_rs", rs, 0);
    chk("rel_rw", rw, 0);
    chk("rel_data", lcd_data, 8'h00);
    chk("rel_on", lcd_on, 1);
    chk("rel_blon", lcd_blon, 1);
    chk("rel_done", done, 0);
    chk("rel_err", err, 0);

`ifndef LCD_BUSY_POLL_EN
    // back-to-back 0x41 / 0x42 with i_valid held
    en_pulses = 0;
    i_valid = 1'b1;
    i_rs    = 1'b1;
    i_data  = 8'h41;
    exp_q.push_back(cyc + lat(1'b1, 8'h41));
    @(negedge clk);
    chk("c1_rs", rs, 1);
    chk("c1_data", lcd_data, 8'h41);
    i_data = 8'h42;
    en_hi = 0; first_en = -1; last_en = -1; rdy_hi = 0;
    for (int k = 1; k <= 2016; k++) begin
      if (en) begin
        en_hi++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (ready) rdy_hi++;
      if (rs !== 1'b1 || lcd_data !== 8'h41) rdy_hi += 1000;
      @(negedge clk);
    end
    chk("en_high_cycles", en_hi, 12);
    chk("en_first", first_en, 3);
    chk("en_last", last_en, 14);
    chk("busy_ready_or_bus", rdy_hi, 0);
    chk("c2017_done", done, 1);
    chk("c2017_ready", ready, 1);
    exp_q.push_back(cyc + lat(1'b1, 8'h42));
    @(negedge clk);
    i_valid = 1'b0;
    chk("b2b_data", lcd_data, 8'h42);
    i_data = 8'h55;
    repeat (5) @(negedge clk);
    chk("data_ignored", lcd_data, 8'h42);
    wait_flag("done_b2b", 2100, 1'b0);
    chk("two_pulses", en_pulses, 2);

    // reset in the middle of the EN pulse
    send(1'b1, 8'h41, lat(1'b1, 8'h41), 1'b1);
    repeat (7) @(negedge clk);
    chk("en_mid_pulse", en, 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_en", en, 0);
    chk("abort_ready", ready, 0);
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", ready, 1);

    send(1'b0, 8'h38, lat(1'b0, 8'h38), 1'b1);
    wait_flag("done_38", 2100, 1'b0);
    send(1'b1, 8'h01, lat(1'b1, 8'h01), 1'b1);
    wait_flag("done_rs1_01", 2100, 1'b0);
    send(1'b0, 8'h01, lat(1'b0, 8'h01), 1'b1);
    wait_flag("done_clear", 82100, 1'b0);
`else
    // three busy reads then ready
    busy_reads = 3; reads = 0; rd_pulses = 0;
    send(1'b1, 8'h41, PHASE * 5 + 1, 1'b1);
    wait_flag("poll_done", 300, 1'b0);
    chk("poll_reads", rd_pulses, 4);
    chk("poll_rs_low", rd_rs_hi, 0);
    chk("poll_rw_idle", rw, 0);

    // DB7 stuck busy: timeout after POLL_LIMIT reads
    busy_reads = 1000; reads = 0; rd_pulses = 0;
    c0 = cyc;
    send(1'b1, 8'h42, 0, 1'b0);
    wait_flag("poll_err", 300, 1'b1);
    chk("poll_err_cycle", cyc - c0, PHASE * 5 + 1);
    chk("poll_err_reads", rd_pulses, 4);
    repeat (20) @(negedge clk);
    chk("poll_err_ready", ready, 1);
`endif

    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
